// File: rtl/serial_acc_pkg.sv
// rtl/serial_acc_pkg.sv - shared types and constants for the bit-serial accumulator
package serial_acc_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bit counter runs WIDTH-1 down to 0, so it needs clog2(WIDTH) bits (at least one).
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/bit_full_addr.sv
// rtl/bit_full_addr.sv - 1-bit full adder from two half adders and an OR for carry
module bit_full_addr (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic s0, c0, c1;

  half_addr u_ha0 (.a_i(a_i), .b_i(b_i), .s_o(s0),  .c_o(c0));
  half_addr u_ha1 (.a_i(s0),  .b_i(c_i), .s_o(s_o), .c_o(c1));

  assign c_o = c0 | c1;

endmodule

// File: rtl/half_addr.sv
// rtl/half_addr.sv - 1-bit half adder
module half_addr (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule

// File: rtl/serial_acc_ctrl.sv
// rtl/serial_acc_ctrl.sv - bit-serial accumulator controller sharing one full-adder cell
// Optional subtract support (op port) is enabled with SERIAL_ACC_SUB_EN.
module serial_acc_ctrl
  import serial_acc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             clear,
`ifdef SERIAL_ACC_SUB_EN
  input  logic             op,
`endif
  output logic [WIDTH-1:0] acc,
  output logic             carry_out,
  output logic             ovf,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic cell_sum, cell_carry;
  logic sub_sel;

`ifdef SERIAL_ACC_SUB_EN
  assign sub_sel = op;
`else
  assign sub_sel = 1'b0;
`endif

  bit_full_addr u_cell (
    .a_i(acc_q[0]),
    .b_i(opnd_q[0]),
    .c_i(carry_q),
    .s_o(cell_sum),
    .c_o(cell_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      opnd_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        // Clear takes effect before an accept in the same cycle, so the operand adds to zero.
        if (clear) begin
          acc_d  = '0;
          cout_d = 1'b0;
          ovf_d  = 1'b0;
        end
        if (in_valid) begin
          opnd_d  = sub_sel ? ~in_data : in_data;
          carry_d = sub_sel;
          cnt_d   = CW'(WIDTH - 1);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        acc_d   = {cell_sum, acc_q[WIDTH-1:1]};
        opnd_d  = opnd_q >> 1;
        carry_d = cell_carry;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          cout_d  = cell_carry;
          ovf_d   = ovf_q | cell_carry;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign acc       = acc_q;
  assign carry_out = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_acc_ctrl.sv
// tb/tb_serial_acc_ctrl.sv - self-checking bench for serial_acc_ctrl against an arithmetic model
module tb_serial_acc_ctrl;

  localparam int W = 8;
  localparam longint MOD = longint'(1) << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         clear = 1'b0;
`ifdef SERIAL_ACC_SUB_EN
  logic         op = 1'b0;
`endif
  logic         in_ready;
  logic [W-1:0] acc;
  logic         carry_out;
  logic         ovf;
  logic         done;

  serial_acc_ctrl #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .clear(clear),
`ifdef SERIAL_ACC_SUB_EN
    .op(op),
`endif
    .acc(acc),
    .carry_out(carry_out),
    .ovf(ovf),
    .done(done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  longint m_acc = 0;
  bit     m_cout = 1'b0;
  bit     m_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_acc = 0;
    m_cout = 1'b0;
    m_ovf = 1'b0;
  endtask

  // Unsigned modulo arithmetic; subtract reports carry as "no borrow".
  task automatic model_apply(input logic [W-1:0] d, input bit sub);
    longint s;
    if (sub) begin
      m_cout = (m_acc >= longint'(d));
      s = m_acc - longint'(d);
      if (s < 0) s += MOD;
      m_acc = s;
    end else begin
      s = m_acc + longint'(d);
      m_cout = (s >= MOD);
      m_acc = s % MOD;
    end
    m_ovf = m_ovf | m_cout;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (in_ready !== 1'b1 && n < 4 * W) begin
      tick();
      n++;
    end
    check({tag, "/ready_wait"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] d, input bit sub, input bit with_clear, input string tag);
    int n = 0;
    check({tag, "/idle_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data = d;
    clear = with_clear;
`ifdef SERIAL_ACC_SUB_EN
    op = sub;
`endif
    tick();
    in_valid = 1'b0;
    clear = 1'b0;
    in_data = W'($urandom);
`ifdef SERIAL_ACC_SUB_EN
    op = 1'($urandom);
`endif
    if (with_clear) model_clear();
    model_apply(d, sub);
    check({tag, "/busy_ready"}, 32'(in_ready), 32'd0);
    while (done !== 1'b1 && n < 4 * W) begin
      tick();
      n++;
    end
    check({tag, "/latency"}, 32'(n), 32'(W));
    check({tag, "/acc"}, 32'(acc), 32'(m_acc));
    check({tag, "/carry_out"}, 32'(carry_out), 32'(m_cout));
    check({tag, "/ovf"}, 32'(ovf), 32'(m_ovf));
    check({tag, "/done_ready"}, 32'(in_ready), 32'd0);
    tick();
    check({tag, "/done_pulse"}, 32'(done), 32'd0);
    check({tag, "/ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int accepts;
    int last_c;
    int dones;
    bit rdy;
    logic [W-1:0] d;

    #12;
    check("reset/ready", 32'(in_ready), 32'd1);
    check("reset/acc", 32'(acc), 32'd0);
    check("reset/carry_out", 32'(carry_out), 32'd0);
    check("reset/ovf", 32'(ovf), 32'd0);
    check("reset/done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_clear();
    check("clear/acc", 32'(acc), 32'd0);

    run_op(8'h05, 1'b0, 1'b0, "add05");
    run_op(8'h03, 1'b0, 1'b0, "add03");
    check("add03/acc_is_08", 32'(acc), 32'h08);

    run_op(8'hF0, 1'b0, 1'b1, "loadF0");
    run_op(8'h20, 1'b0, 1'b0, "add20");
    check("add20/acc_is_10", 32'(acc), 32'h10);
    run_op(8'h01, 1'b0, 1'b0, "add01");
    check("add01/ovf_sticky", 32'(ovf), 32'd1);

    run_op(8'hAA, 1'b0, 1'b1, "clear_accept");
    check("clear_accept/acc_is_AA", 32'(acc), 32'hAA);

    run_op(8'hF0, 1'b0, 1'b0, "preovf");
    in_valid = 1'b1;
    in_data = 8'h5C;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    model_clear();
    check("midreset/ready", 32'(in_ready), 32'd1);
    check("midreset/acc", 32'(acc), 32'd0);
    check("midreset/ovf", 32'(ovf), 32'd0);
    check("midreset/carry_out", 32'(carry_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 2 * W; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    check("midreset/no_done", 32'(dones), 32'd0);
    run_op(8'h07, 1'b0, 1'b0, "after_reset");
    check("after_reset/acc_is_07", 32'(acc), 32'h07);

    accepts = 0;
    last_c = -1;
    in_valid = 1'b1;
    for (int c = 0; c < 5 * (W + 2); c++) begin
      in_data = W'($urandom);
      rdy = in_ready;
      d = in_data;
      tick();
      in_data = W'($urandom);
      if (rdy) begin
        accepts++;
        if (last_c >= 0) check("held/interval", 32'(c - last_c), 32'(W + 2));
        last_c = c;
        model_apply(d, 1'b0);
      end
      if (done === 1'b1) begin
        check("held/acc", 32'(acc), 32'(m_acc));
        check("held/carry_out", 32'(carry_out), 32'(m_cout));
      end
    end
    in_valid = 1'b0;
    check("held/accepts", 32'(accepts), 32'd5);
    wait_ready("held");
    check("held/final_acc", 32'(acc), 32'(m_acc));

    for (int i = 0; i < 20; i++) begin
      run_op(W'($urandom), 1'b0, ($urandom_range(0, 4) == 0), "rand_add");
    end

`ifdef SERIAL_ACC_SUB_EN
    run_op(8'h05, 1'b0, 1'b1, "sub_pre05");
    run_op(8'h07, 1'b1, 1'b0, "sub07");
    check("sub07/acc_is_FE", 32'(acc), 32'hFE);
    check("sub07/no_borrow", 32'(carry_out), 32'd0);
    run_op(8'h0E, 1'b1, 1'b0, "sub0E");
    check("sub0E/acc_is_F0", 32'(acc), 32'hF0);
    check("sub0E/no_borrow", 32'(carry_out), 32'd1);
    for (int i = 0; i < 20; i++) begin
      run_op(W'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0), "rand_mix");
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
